// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with a zero-latency Mealy match pulse.
// Supports overlap modes and a saturating match counter. The pattern can be reloaded at run time.
module seq_detect_prog #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1001),
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [PAT_W-2:0]  hist, hist_d, hist_shift;
  logic [FILL_W-1:0] fill, fill_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              accept;
  logic              match;

  // A history of one bit has nothing to keep when shifting.
  generate
    if (PAT_W == 2) begin : g_shift_min
      assign hist_shift = din;
    end else begin : g_shift
      assign hist_shift = {hist[PAT_W-3:0], din};
    end
  endgenerate

  // Match decode: only accepted cycles with a full history can fire.
  always_comb begin
    accept = en && !cfg_load;
    match  = accept && (fill == FILL_MAX) && ({hist, din} == pat_q);
  end

  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist;
    fill_d = fill;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      // Non-overlap mode forgets the matched bits so they cannot seed the next match.
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill != FILL_MAX) begin
        fill_d = fill + FILL_W'(1);
      end
    end
  end

  // The clear request takes priority over a same-cycle increment.
  always_comb begin
    cnt_d = match_cnt;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && !cnt_sat) begin
      cnt_d = match_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    dout    = match;
    cnt_sat = &match_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q     <= RST_PAT;
      ovl_q     <= 1'b1;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else begin
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
      hist      <= hist_d;
      fill      <= fill_d;
      match_cnt <= cnt_d;
    end
  end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter: PAT_W, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter: RST_PAT, default 4'b1001 (PAT_W bits), pattern loaded at reset.
REQ-003 Parameter: CNT_W, default 8, match counter width; legal range 1..32.
REQ-004 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous active-low reset; low clears all state immediately, release synchronous to clk.
REQ-006 Port: en, input, 1, din is sampled only in cycles with en=1.
REQ-007 Port: din, input, 1, serial data bit; in each accepted cycle it is the newest bit.
REQ-008 Port: cfg_load, input, 1, loads cfg_pattern and cfg_overlap and flushes history.
REQ-009 Port: cfg_pattern, input, PAT_W, target pattern; MSB is the first bit received.
REQ-010 Port: cfg_overlap, input, 1, overlap mode: 1 means overlapping matches, 0 means non-overlapping.
REQ-011 Port: cnt_clr, input, 1, synchronous clear of match_cnt.
REQ-012 Port: dout, output, 1, Mealy match pulse, combinational from state, din, en and cfg_load.
REQ-013 Port: match_cnt, output, CNT_W, number of matches since reset or clear, saturating.
REQ-014 Port: cnt_sat, output, 1, high while match_cnt equals all-ones.

Function
REQ-015 Registers: pat_q (PAT_W bits), ovl_q, hist (PAT_W-1 bits; LSB is the newest bit), fill (0..PAT_W-1), match_cnt.
- fill counts the valid history bits.
REQ-016 An accepted cycle is one with en=1 and cfg_load=0.
- Non-accepted cycles: hist and fill hold, dout=0.
REQ-017 dout=1 when all of the following hold:
- the cycle is accepted;
- fill==PAT_W-1;
- {hist,din}==pat_q.
- This gives zero latency: dout is asserted in the same cycle as the final pattern bit.
REQ-018 Accepted cycle updates:
- hist <= {hist[PAT_W-3:0],din};
- fill <= min(fill+1, PAT_W-1).
REQ-019 Accepted cycle with dout=1 and ovl_q=0: fill <= 0, so the matched bits cannot begin another match; hist is still updated.
REQ-020 Accepted cycle with dout=1 and ovl_q=1: fill stays at PAT_W-1, so the matched suffix can begin another match.
REQ-021 cfg_load=1, regardless of en:
- pat_q <= cfg_pattern, ovl_q <= cfg_overlap;
- hist <= 0, fill <= 0;
- din is discarded, dout=0;
- match_cnt is unaffected.
REQ-022 match_cnt increments by 1 in each cycle with dout=1.
- At all-ones it holds (no wrap) and cnt_sat stays 1.
REQ-023 cnt_clr=1: match_cnt <= 0 next edge; cnt_clr wins over a simultaneous increment.
REQ-024 Pattern compare is exact over all PAT_W bits.
- There are no don't-care bits.
- An all-zero or all-one pattern is legal.
REQ-025 No X propagation: dout is 0 whenever en=0 or cfg_load=1, regardless of din.

Reset
REQ-026 reset low sets the following values:
- pat_q=RST_PAT, ovl_q=1;
- hist=0, fill=0;
- match_cnt=0, cnt_sat=0.
- dout evaluates to 0 because fill=0.
REQ-027 Reset asserted mid-sequence discards partial history; detection restarts from an empty history after release.

Verification (PAT_W=4, RST_PAT=1001 unless noted)
REQ-028 Overlap test:
- Stimulus: after reset, en=1, din=1,0,0,1,0,0,1.
- Required: dout=1 on bits 4 and 7 only; match_cnt=2.
REQ-029 Non-overlap test:
- Stimulus: cfg_load with cfg_pattern=1001, cfg_overlap=0, then din=1,0,0,1,0,0,1.
- Required: dout=1 on bit 4 only; match_cnt=1.
REQ-030 Reload test:
- Stimulus: cfg_load to 1011 with overlap=1 after a partial 10, then din=1,0,1,1,0,1,1.
- Required: no dout during the load cycle; dout on bits 4 and 7 only.
REQ-031 Enable gap test:
- Stimulus: din=1,0; then en=0 for 3 cycles with din toggling; then en=1, din=0,1.
- Required: dout=0 throughout the gap; dout=1 on the final bit.
REQ-032 Saturation and clear test:
- Stimulus: CNT_W=2, five overlapping 1001 matches.
- Required: match_cnt=3 and cnt_sat=1 after the 3rd match and held through the 5th.
- Stimulus: cnt_clr asserted in the same cycle as a match.
- Required: match_cnt=0 and cnt_sat=0 next cycle.
REQ-033 Reset mid-operation test:
- Stimulus: din=1,0,0; reset pulse low for 1 cycle; then din=1.
- Required: dout=0.
- Stimulus: then din=0,0,1.
- Required: dout=1 on that final 1.
